// File: rtl/pe_pkg.sv
// Shared types and default geometry for the PE array layer sequencer.
package pe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_FILTER,
    S_LOAD_IFMAP,
    S_CONV,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  localparam int DEF_FILTER_ROWS = 3;
  localparam int DEF_IFMAP_ROWS  = 5;
  localparam int DEF_PIPE_LAT    = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pe_array_sequencer.sv
// Layer-level control FSM for the PE array: filter load, ifmap load, conv window,
// pipeline drain and a one-cycle done pulse.
module pe_array_sequencer
  import pe_pkg::*;
#(
  parameter int FILTER_ROWS = DEF_FILTER_ROWS,
  parameter int IFMAP_ROWS  = DEF_IFMAP_ROWS,
  parameter int PIPE_LAT    = DEF_PIPE_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic reuse_filter_i,
  input  logic src_valid_i,
  output logic read_new_filter_val,
  output logic read_new_ifmap_val,
  output logic start_conv,
  output logic ofmap_valid_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CONV_CYCLES = IFMAP_ROWS - FILTER_ROWS + 1;
  localparam int CNT_W       = $clog2(max3(IFMAP_ROWS, CONV_CYCLES, PIPE_LAT) + 1);

  seq_state_t           r_state;
  seq_state_t           w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_filter_loaded;
  logic [PIPE_LAT-1:0]  r_pipe;

  logic w_filter_last;
  logic w_ifmap_last;
  logic w_conv_last;
  logic w_drain_last;

  assign w_filter_last = (r_cnt == CNT_W'(FILTER_ROWS - 1));
  assign w_ifmap_last  = (r_cnt == CNT_W'(IFMAP_ROWS - 1));
  assign w_conv_last   = (r_cnt == CNT_W'(CONV_CYCLES - 1));
  assign w_drain_last  = (r_cnt == CNT_W'(PIPE_LAT - 1));

  // NOTE: state is updated with non-blocking assignments so every register
  // in this clock domain sees the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: the default assignment first guarantees no latch is inferred for
  // any path through the case statement.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:
        if (start_i) w_next_state = (reuse_filter_i && r_filter_loaded) ? S_LOAD_IFMAP
                                                                        : S_LOAD_FILTER;
      S_LOAD_FILTER: if (src_valid_i && w_filter_last) w_next_state = S_LOAD_IFMAP;
      S_LOAD_IFMAP:  if (src_valid_i && w_ifmap_last)  w_next_state = S_CONV;
      S_CONV:        if (w_conv_last)                  w_next_state = S_DRAIN;
      S_DRAIN:       if (w_drain_last)                 w_next_state = S_DONE;
      S_DONE:        w_next_state = S_IDLE;
      default:       w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    read_new_filter_val = (r_state == S_LOAD_FILTER) && src_valid_i;
    read_new_ifmap_val  = (r_state == S_LOAD_IFMAP) && src_valid_i;
    start_conv          = (r_state == S_CONV);
    busy_o              = (r_state != S_IDLE);
    done_o              = (r_state == S_DONE);
  end

  // Phase counter is shared by all timed states; it always leaves a state at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt           <= '0;
      r_filter_loaded <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD_FILTER:
          if (src_valid_i) begin
            if (w_filter_last) begin
              r_cnt           <= '0;
              r_filter_loaded <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        S_LOAD_IFMAP:
          if (src_valid_i) r_cnt <= w_ifmap_last ? '0 : r_cnt + 1'b1;
        S_CONV:  r_cnt <= w_conv_last  ? '0 : r_cnt + 1'b1;
        S_DRAIN: r_cnt <= w_drain_last ? '0 : r_cnt + 1'b1;
        default: r_cnt <= '0;
      endcase
    end
  end

  // Models the array latency so ofmap_valid_o trails start_conv by PIPE_LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pipe <= '0;
    else     r_pipe <= PIPE_LAT'({r_pipe, start_conv});
  end

  assign ofmap_valid_o = r_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Scoreboard bench for pe_array_sequencer: stimulus pushes expected per-cycle
// output vectors, a negedge monitor pops and compares whenever the DUT is active.
module tb_pe_array_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start_i;
  logic reuse_filter_i;
  logic src_valid_i;
  logic read_new_filter_val;
  logic read_new_ifmap_val;
  logic start_conv;
  logic ofmap_valid_o;
  logic busy_o;
  logic done_o;

  pe_array_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .start_i             (start_i),
    .reuse_filter_i      (reuse_filter_i),
    .src_valid_i         (src_valid_i),
    .read_new_filter_val (read_new_filter_val),
    .read_new_ifmap_val  (read_new_ifmap_val),
    .start_conv          (start_conv),
    .ofmap_valid_o       (ofmap_valid_o),
    .busy_o              (busy_o),
    .done_o              (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output vector order: {busy, filter_read, ifmap_read, start_conv, ofmap_valid, done}
  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, req);
  endtask

  function automatic logic [5:0] out_vec();
    return {busy_o, read_new_filter_val, read_new_ifmap_val, start_conv, ofmap_valid_o, done_o};
  endfunction

  // Monitor: one-hot property every cycle, scoreboard pop on any activity.
  always @(negedge clk) begin
    logic [5:0] act;
    exp_t       e;
    act = out_vec();
    if (!rst) begin
      check("onehot", 32'($countones({read_new_filter_val, read_new_ifmap_val, start_conv}) <= 1), 32'd1);
      if (act != 6'd0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(act), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", e.cyc, cyc);
          check("outputs", 32'(act), 32'(e.vec));
        end
      end
    end
  end

  // Hand-computed per-signal cycle masks, bit n = cycle n after the start cycle.
  localparam logic [31:0] NOM_FILT = 32'h0000_000E;  // 1-3
  localparam logic [31:0] NOM_IFM  = 32'h0000_01F0;  // 4-8
  localparam logic [31:0] NOM_CONV = 32'h0000_0E00;  // 9-11
  localparam logic [31:0] NOM_OFM  = 32'h0000_7000;  // 12-14
  localparam int          NOM_DONE = 15;
  localparam logic [31:0] STL_FILT = 32'h0000_0062;  // 1,5,6
  localparam logic [31:0] STL_IFM  = 32'h0000_0F80;  // 7-11
  localparam logic [31:0] STL_CONV = 32'h0000_7000;  // 12-14
  localparam logic [31:0] STL_OFM  = 32'h0003_8000;  // 15-17
  localparam int          STL_DONE = 18;
  localparam logic [31:0] REU_IFM  = 32'h0000_003E;  // 1-5
  localparam logic [31:0] REU_CONV = 32'h0000_01C0;  // 6-8
  localparam logic [31:0] REU_OFM  = 32'h0000_0E00;  // 9-11
  localparam int          REU_DONE = 12;

  task automatic push_layer(input int t0, input logic [31:0] filt, input logic [31:0] ifm,
                            input logic [31:0] conv, input logic [31:0] ofm,
                            input int done_rel, input int upto);
    exp_t e;
    for (int rel = 1; rel <= upto; rel++) begin
      e.cyc = t0 + rel;
      e.vec = {1'b1, filt[rel], ifm[rel], conv[rel], ofm[rel], rel == done_rel};
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start_i     = 1'b0;
    src_valid_i = 1'b1;
    repeat (n) tick();
  endtask

  task automatic run_layer(input logic reuse, input int stall_lo, input int stall_hi,
                           input logic hold, input logic [31:0] filt, input logic [31:0] ifm,
                           input logic [31:0] conv, input logic [31:0] ofm, input int done_rel);
    int t0;
    t0 = cyc;
    push_layer(t0, filt, ifm, conv, ofm, done_rel, done_rel);
    reuse_filter_i = reuse;
    for (int rel = 0; rel <= done_rel; rel++) begin
      start_i     = (rel == 0) || hold;
      src_valid_i = !(rel >= stall_lo && rel <= stall_hi);
      tick();
    end
    start_i        = hold;
    src_valid_i    = 1'b1;
    reuse_filter_i = 1'b0;
  endtask

  task automatic run_reset_in_conv();
    int t0;
    t0 = cyc;
    push_layer(t0, NOM_FILT, NOM_IFM, NOM_CONV, NOM_OFM, NOM_DONE, 9);
    for (int rel = 0; rel < 10; rel++) begin
      start_i     = (rel == 0);
      src_valid_i = 1'b1;
      tick();
    end
    rst = 1'b1;
    #1;
    check("reset_in_conv_outputs", 32'(out_vec()), 32'd0);
    tick();
    rst = 1'b0;
    idle(20);
    check("reset_in_conv_no_pending", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    start_i        = 1'b0;
    reuse_filter_i = 1'b0;
    src_valid_i    = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'(out_vec()), 32'd0);
    rst = 1'b0;
    idle(2);

    // Reuse requested with no filter resident: full nominal sequence.
    run_layer(1'b1, -1, -2, 1'b0, NOM_FILT, NOM_IFM, NOM_CONV, NOM_OFM, NOM_DONE);
    idle(2);
    run_layer(1'b0, -1, -2, 1'b0, NOM_FILT, NOM_IFM, NOM_CONV, NOM_OFM, NOM_DONE);
    idle(2);
    run_layer(1'b0, 2, 4, 1'b0, STL_FILT, STL_IFM, STL_CONV, STL_OFM, STL_DONE);
    idle(2);
    run_layer(1'b1, -1, -2, 1'b0, 32'd0, REU_IFM, REU_CONV, REU_OFM, REU_DONE);
    idle(2);
    run_reset_in_conv();
    run_layer(1'b0, -1, -2, 1'b0, NOM_FILT, NOM_IFM, NOM_CONV, NOM_OFM, NOM_DONE);
    idle(2);

    // start_i held high: one full layer, one IDLE cycle, then a second layer.
    run_layer(1'b0, -1, -2, 1'b1, NOM_FILT, NOM_IFM, NOM_CONV, NOM_OFM, NOM_DONE);
    run_layer(1'b0, -1, -2, 1'b0, NOM_FILT, NOM_IFM, NOM_CONV, NOM_OFM, NOM_DONE);
    idle(6);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
